// File: rtl/bsg_link_pearl_pkg.sv
// -----------------------------------------------------------------------------
// bsg_link_pearl_pkg
//
// Shared types and helpers for the link bring-up reset sequencer.
//   bsg_link_pearl_reset_seq_state_e : FSM state encoding
//   bsg_link_pearl_reset_lines_s     : the four reset lines
//                                      (token, up_io, down_io, core)
//   reset_lines_for_state()          : per-state reset line levels
//   state_is_busy()                  : true for the timed sequence states
// -----------------------------------------------------------------------------
package bsg_link_pearl_pkg;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_assert   = 3'd1,
    e_token_hi = 3'd2,
    e_token_lo = 3'd3,
    e_up_rel   = 3'd4,
    e_dn_rel   = 3'd5,
    e_core_rel = 3'd6,
    e_done     = 3'd7
  } bsg_link_pearl_reset_seq_state_e;

  typedef struct packed {
    logic token;
    logic up_io;
    logic down_io;
    logic core;
  } bsg_link_pearl_reset_lines_s;

  // Reset line levels for a given state. IDLE depends on whether the link is
  // meant to sit in reset before the first bring-up request.
  function automatic bsg_link_pearl_reset_lines_s reset_lines_for_state
    (input bsg_link_pearl_reset_seq_state_e state,
     input logic                            start_in_reset);
    bsg_link_pearl_reset_lines_s lines;
    case (state)
      e_idle:     lines = start_in_reset ? 4'b0111 : 4'b0000;
      e_assert:   lines = 4'b0111;
      e_token_hi: lines = 4'b1111;
      e_token_lo: lines = 4'b0111;
      e_up_rel:   lines = 4'b0011;
      e_dn_rel:   lines = 4'b0001;
      e_core_rel: lines = 4'b0001;
      e_done:     lines = 4'b0000;
      default:    lines = 4'b0111;
    endcase
    return lines;
  endfunction

  // The dwell-timed states, i.e. everything between IDLE/DONE.
  function automatic logic state_is_busy
    (input bsg_link_pearl_reset_seq_state_e state);
    logic busy;
    case (state)
      e_assert, e_token_hi, e_token_lo,
      e_up_rel, e_dn_rel, e_core_rel: busy = 1'b1;
      default:                        busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/bsg_link_pearl_reset_seq_timer.sv
// -----------------------------------------------------------------------------
// bsg_link_pearl_reset_seq_timer
//
// Dwell down-counter for the reset sequencer. On load_i the counter takes
// hold_cycles_p-1; otherwise, while en_i is high, it counts down and rests at
// zero. zero_o tells the FSM the current state has been held long enough.
//
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset (counter to 0)
//   en_i      : count enable (low freezes the counter)
//   load_i    : reload on state entry
//   zero_o    : count is zero
// -----------------------------------------------------------------------------
module bsg_link_pearl_reset_seq_timer #(
  parameter int unsigned hold_cycles_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic load_i,
  output logic zero_o
);

  localparam int unsigned width_lp = $clog2(hold_cycles_p + 1);
  localparam logic [width_lp-1:0] load_val_lp = width_lp'(hold_cycles_p - 1);
  localparam logic [width_lp-1:0] one_lp      = width_lp'(1);

  logic [width_lp-1:0] count_q;
  logic [width_lp-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_lp;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - one_lp;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bsg_link_pearl_reset_seq.sv
// -----------------------------------------------------------------------------
// bsg_link_pearl_reset_seq
//
// Link bring-up reset sequencer. A start_i pulse in IDLE or DONE walks the
// link resets through ASSERT, TOKEN_HI, TOKEN_LO, UP_REL, DN_REL and CORE_REL,
// each held for hold_cycles_p clocks, ending in DONE with all resets released.
// Outputs are registered from the next state so they move on the same edge
// as the FSM.
//
// Parameters:
//   hold_cycles_p    : dwell per sequence state (1..2^16-1)
//   start_in_reset_p : 1 = link/core resets asserted while IDLE
//
// Ports:
//   clk_i               : clock
//   reset_n_i           : asynchronous active-low reset (deassertion must be
//                         synchronous to clk_i; no synchronizer inside)
//   start_i             : single-cycle bring-up request
//   async_token_reset_o : link token-reset pulse
//   up_io_reset_o       : upstream link IO reset
//   down_io_reset_o     : downstream link IO reset
//   core_reset_o        : link core-side reset
//   busy_o              : sequence in progress
//   done_o              : sequence complete
//
// Optional feature, macro BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN:
//   override_v_i        : when high, reset outputs follow override_lines_i,
//                         FSM and timer freeze, busy_o/done_o forced low
//   override_lines_i    : {token, up_io, down_io, core}
// -----------------------------------------------------------------------------
module bsg_link_pearl_reset_seq
  import bsg_link_pearl_pkg::*;
#(
  parameter int unsigned hold_cycles_p    = 16,
  parameter bit          start_in_reset_p = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
  input  logic       override_v_i,
  input  logic [3:0] override_lines_i,
`endif
  output logic       async_token_reset_o,
  output logic       up_io_reset_o,
  output logic       down_io_reset_o,
  output logic       core_reset_o,
  output logic       busy_o,
  output logic       done_o
);

  bsg_link_pearl_reset_seq_state_e state_q, state_d;
  bsg_link_pearl_reset_lines_s     lines_q, lines_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            timer_zero;
  logic                            timer_load;
  logic                            freeze;

`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
  assign freeze = override_v_i;
`else
  assign freeze = 1'b0;
`endif

  // Next-state logic: timed states advance in order once the dwell expires.
  always_comb begin
    state_d = state_q;
    if (freeze) begin
      state_d = state_q;
    end else begin
      case (state_q)
        e_idle, e_done: state_d = start_i    ? e_assert   : state_q;
        e_assert:       state_d = timer_zero ? e_token_hi : state_q;
        e_token_hi:     state_d = timer_zero ? e_token_lo : state_q;
        e_token_lo:     state_d = timer_zero ? e_up_rel   : state_q;
        e_up_rel:       state_d = timer_zero ? e_dn_rel   : state_q;
        e_dn_rel:       state_d = timer_zero ? e_core_rel : state_q;
        e_core_rel:     state_d = timer_zero ? e_done     : state_q;
        default:        state_d = e_idle;
      endcase
    end
  end

  // Every state change (including DONE->ASSERT) restarts the dwell.
  assign timer_load = (state_d != state_q);

  // Output decode from the next state, so outputs register alongside it.
  always_comb begin
    lines_d = reset_lines_for_state(state_d, start_in_reset_p);
    busy_d  = state_is_busy(state_d);
    done_d  = (state_d == e_done);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      lines_q <= reset_lines_for_state(e_idle, start_in_reset_p);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  bsg_link_pearl_reset_seq_timer #(
    .hold_cycles_p(hold_cycles_p)
  ) timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (~freeze),
    .load_i   (timer_load),
    .zero_o   (timer_zero)
  );

`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
  // Override path bypasses the registers; the frozen FSM keeps its place.
  always_comb begin
    if (override_v_i) begin
      async_token_reset_o = override_lines_i[3];
      up_io_reset_o       = override_lines_i[2];
      down_io_reset_o     = override_lines_i[1];
      core_reset_o        = override_lines_i[0];
      busy_o              = 1'b0;
      done_o              = 1'b0;
    end else begin
      async_token_reset_o = lines_q.token;
      up_io_reset_o       = lines_q.up_io;
      down_io_reset_o     = lines_q.down_io;
      core_reset_o        = lines_q.core;
      busy_o              = busy_q;
      done_o              = done_q;
    end
  end
`else
  assign async_token_reset_o = lines_q.token;
  assign up_io_reset_o       = lines_q.up_io;
  assign down_io_reset_o     = lines_q.down_io;
  assign core_reset_o        = lines_q.core;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
`endif

endmodule

// File: tb/tb_bsg_link_pearl_reset_seq.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_link_pearl_reset_seq. Two instances share clock and reset:
// u16 (hold 16, start in reset) and u1 (hold 1, idle out of reset). The
// reference model tracks only "sequence started at edge t0"; expected outputs
// come from the phase (cycles since t0) / hold.
// Output vectors are {token, up_io, down_io, core, busy, done}.
// -----------------------------------------------------------------------------
module tb_bsg_link_pearl_reset_seq;

  localparam int H16 = 16;
  localparam int H1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st16, st1;
  logic       ov16;
  logic [3:0] ovl16;

  logic tok16, up16, dn16, core16, busy16, done16;
  logic tok1, up1, dn1, core1, busy1, done1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit act16 = 1'b0, act1 = 1'b0;
  int t016  = 0,    t01  = 0;

  bsg_link_pearl_reset_seq #(.hold_cycles_p(16), .start_in_reset_p(1'b1)) u16 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(st16),
`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
    .override_v_i(ov16), .override_lines_i(ovl16),
`endif
    .async_token_reset_o(tok16), .up_io_reset_o(up16), .down_io_reset_o(dn16),
    .core_reset_o(core16), .busy_o(busy16), .done_o(done16));

  bsg_link_pearl_reset_seq #(.hold_cycles_p(1), .start_in_reset_p(1'b0)) u1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(st1),
`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
    .override_v_i(1'b0), .override_lines_i(4'b0000),
`endif
    .async_token_reset_o(tok1), .up_io_reset_o(up1), .down_io_reset_o(dn1),
    .core_reset_o(core1), .busy_o(busy1), .done_o(done1));

  function automatic logic [5:0] phase_out(input int p);
    case (p)
      0:       return 6'b011110;  // ASSERT
      1:       return 6'b111110;  // TOKEN_HI
      2:       return 6'b011110;  // TOKEN_LO
      3:       return 6'b001110;  // UP_REL
      4:       return 6'b000110;  // DN_REL
      5:       return 6'b000110;  // CORE_REL
      default: return 6'b000001;  // DONE
    endcase
  endfunction

  function automatic logic [5:0] model_out(input bit act, input int t0,
                                           input int h, input bit sirp);
    if (!act) return sirp ? 6'b011100 : 6'b000000;
    return phase_out((cyc - t0) / h);
  endfunction

  task automatic model_edge(input bit start, inout bit act, inout int t0,
                            input int h, input bit frozen);
    if (!rst_n) act = 1'b0;
    else if (frozen) begin
      if (act) t0 = t0 + 1;
    end else if (start && (!act || ((cyc - 1 - t0) / h) >= 6)) begin
      act = 1'b1;
      t0  = cyc;
    end
  endtask

  function automatic logic [5:0] obs16();
    return {tok16, up16, dn16, core16, busy16, done16};
  endfunction

  function automatic logic [5:0] obs1();
    return {tok1, up1, dn1, core1, busy1, done1};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the negedge.
  task automatic tick();
    logic [5:0] e16;
    @(posedge clk);
    cyc++;
    model_edge(st16, act16, t016, H16, ov16);
    model_edge(st1,  act1,  t01,  H1,  1'b0);
    @(negedge clk);
    e16 = ov16 ? {ovl16, 2'b00} : model_out(act16, t016, H16, 1'b1);
    chk("u16_model", obs16(), e16);
    chk("u1_model",  obs1(),  model_out(act1, t01, H1, 1'b0));
  endtask

  initial begin
    rst_n = 1'b1; st16 = 1'b0; st1 = 1'b0; ov16 = 1'b0; ovl16 = 4'b0000;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_u16", obs16(), 6'b011100);
    chk("reset_u1",  obs1(),  6'b000000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed bring-up from IDLE; i counts edges after the start edge.
    st16 = 1'b1; st1 = 1'b1;
    tick();
    st16 = 1'b0; st1 = 1'b0;
    chk("u16_assert_entry", obs16(), 6'b011110);
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 15) chk("u16_assert_last",  obs16(), 6'b011110);
      if (i == 16) chk("u16_tokhi_first",  obs16(), 6'b111110);
      if (i == 31) chk("u16_tokhi_last",   obs16(), 6'b111110);
      if (i == 32) chk("u16_toklo_first",  obs16(), 6'b011110);
      if (i == 48) chk("u16_uprel_first",  obs16(), 6'b001110);
      if (i == 95) chk("u16_corerel_last", obs16(), 6'b000110);
      if (i == 96) chk("u16_done_first",   obs16(), 6'b000001);
      if (i == 5)  chk("u1_corerel",       obs1(),  6'b000110);
      if (i == 6)  chk("u1_done",          obs1(),  6'b000001);
    end

    // Restart from DONE; a start pulse during TOKEN_LO must be ignored.
    st16 = 1'b1;
    tick();
    chk("u16_restart", obs16(), 6'b011110);
    for (int i = 1; i <= 100; i++) begin
      st16 = (i == 40);
      tick();
      if (i == 40) chk("u16_toklo_ignore", obs16(), 6'b011110);
      if (i == 95) chk("u16_restart_core", obs16(), 6'b000110);
      if (i == 96) chk("u16_restart_done", obs16(), 6'b000001);
    end
    st16 = 1'b0;

    // Asynchronous reset for 3 cycles in DN_REL; no resume afterwards.
    st16 = 1'b1;
    tick();
    st16 = 1'b0;
    for (int i = 1; i <= 70; i++) tick();
    chk("u16_dnrel", obs16(), 6'b000110);
    #2 rst_n = 1'b0;
    #1;
    act16 = 1'b0; act1 = 1'b0;
    chk("u16_async_reset", obs16(), 6'b011100);
    chk("u1_async_reset",  obs1(),  6'b000000);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("u16_stays_idle", obs16(), 6'b011100);

    // Randomized start pulses against the model.
    for (int i = 0; i < 600; i++) begin
      st16 = ($urandom_range(0, 59) == 0);
      st1  = ($urandom_range(0, 4) == 0);
      tick();
    end
    st16 = 1'b0; st1 = 1'b0;

`ifdef BSG_LINK_PEARL_RESET_SEQ_OVERRIDE_EN
    // Override mid-UP_REL, then resume with the remaining dwell.
    repeat (100) tick();
    st16 = 1'b1;
    tick();
    st16 = 1'b0;
    for (int i = 1; i <= 52; i++) tick();
    ov16 = 1'b1; ovl16 = 4'b1010;
    repeat (5) tick();
    chk("u16_override", obs16(), 6'b101000);
    ov16 = 1'b0;
    repeat (60) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
